// File: rtl/breath_led_multi.sv
// Multi-channel PWM LED engine: one shared prescaler and frame counter, per-channel
// off/solid/breath/sawtooth level generators loaded through a single-cycle config port.
module breath_led_multi #(
    parameter int NUM_CH     = 4,
    parameter int CLK_DIV    = 100,
    parameter int PWM_MAX    = 1000,
    parameter int STEP_MAX   = 10,
    parameter int START_STEP = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              sw_ctrl,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [9:0]        cfg_step,
    input  logic [9:0]        cfg_level,
    output logic [NUM_CH-1:0] led,
    output logic              frame_pulse
);

    localparam int DW = $clog2(PWM_MAX + 1);
    localparam int SW = 10;
    localparam int AW = ((DW > SW) ? DW : SW) + 1;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [4:0] NUM_CH_W = 5'(NUM_CH);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_SOLID  = 2'd1,
        MODE_BREATH = 2'd2,
        MODE_SAW    = 2'd3
    } mode_e;

    logic [CW-1:0] div_cnt;
    logic [DW-1:0] pwm_cnt;
    logic          tick;
    logic          frame_end;

    mode_e         mode_q  [NUM_CH];
    logic [SW-1:0] step_q  [NUM_CH];
    logic [DW-1:0] lvl_q   [NUM_CH];
    logic          dir_q   [NUM_CH];
    logic [DW-1:0] lvl_nxt [NUM_CH];
    logic          dir_nxt [NUM_CH];
    logic [NUM_CH-1:0] led_q;

    logic          wr_en;
    logic [SW-1:0] wr_step;
    logic [DW-1:0] wr_lvl;

    assign tick      = (div_cnt == CW'(CLK_DIV - 1));
    assign frame_end = tick && (pwm_cnt == DW'(PWM_MAX - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt     <= '0;
            pwm_cnt     <= '0;
            frame_pulse <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                pwm_cnt <= (pwm_cnt == DW'(PWM_MAX - 1)) ? '0 : pwm_cnt + 1'b1;
            end
            frame_pulse <= frame_end;
        end
    end

    // Config write decode with step and level clamping; off mode always parks at level 0.
    always_comb begin
        wr_en   = cfg_we && ({1'b0, cfg_ch} < NUM_CH_W);
        wr_step = cfg_step;
        wr_lvl  = DW'(cfg_level);
        if (cfg_step == '0) begin
            wr_step = SW'(1);
        end else if (cfg_step >= SW'(STEP_MAX)) begin
            wr_step = SW'(STEP_MAX);
        end
        if (mode_e'(cfg_mode) == MODE_OFF) begin
            wr_lvl = '0;
        end else if (AW'(cfg_level) > AW'(PWM_MAX)) begin
            wr_lvl = DW'(PWM_MAX);
        end
    end

    // Frame-end level stepping; sums are one bit wider than the operands so they never wrap.
    always_comb begin : level_next
        logic [AW-1:0] up_sum;
        up_sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
            lvl_nxt[i] = lvl_q[i];
            dir_nxt[i] = dir_q[i];
            up_sum     = AW'(lvl_q[i]) + AW'(step_q[i]);
            case (mode_q[i])
                MODE_OFF:   lvl_nxt[i] = '0;
                MODE_SOLID: lvl_nxt[i] = lvl_q[i];
                MODE_BREATH: begin
                    if (!dir_q[i]) begin
                        if (up_sum >= AW'(PWM_MAX)) begin
                            lvl_nxt[i] = DW'(PWM_MAX);
                            dir_nxt[i] = 1'b1;
                        end else begin
                            lvl_nxt[i] = DW'(up_sum);
                        end
                    end else if (AW'(lvl_q[i]) <= AW'(step_q[i])) begin
                        lvl_nxt[i] = '0;
                        dir_nxt[i] = 1'b0;
                    end else begin
                        lvl_nxt[i] = lvl_q[i] - DW'(step_q[i]);
                    end
                end
                MODE_SAW: lvl_nxt[i] = (up_sum >= AW'(PWM_MAX)) ? '0 : DW'(up_sum);
            endcase
        end
    end

    // NOTE: the per-channel arrays are small flop banks that must come up in a known state, so they are reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i] <= MODE_OFF;
                step_q[i] <= SW'(START_STEP);
                lvl_q[i]  <= '0;
                dir_q[i]  <= 1'b0;
                led_q[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_en && (cfg_ch == 4'(i))) begin
                    mode_q[i] <= mode_e'(cfg_mode);
                    step_q[i] <= wr_step;
                    lvl_q[i]  <= wr_lvl;
                    dir_q[i]  <= 1'b0;
                end else if (frame_end) begin
                    lvl_q[i] <= lvl_nxt[i];
                    dir_q[i] <= dir_nxt[i];
                end
                led_q[i] <= (mode_q[i] != MODE_OFF) && (pwm_cnt < lvl_q[i]);
            end
        end
    end

    assign led = led_q & {NUM_CH{sw_ctrl}};

endmodule

// File: tb/tb_breath_led_multi.sv
// Scoreboard bench: each frame's expected per-channel high-cycle count is queued by the
// stimulus; a monitor integrates led over each frame window and compares on frame_pulse.
module tb_breath_led_multi;

    localparam int NCH = 4;

    logic           sys_clk;
    logic           sys_rst_n;
    logic           sw_ctrl;
    logic           cfg_we;
    logic [3:0]     cfg_ch;
    logic [1:0]     cfg_mode;
    logic [9:0]     cfg_step;
    logic [9:0]     cfg_level;
    logic [NCH-1:0] led;
    logic           frame_pulse;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q [$];
    int tag_q [$];

    breath_led_multi #(
        .NUM_CH(NCH), .CLK_DIV(2), .PWM_MAX(10), .STEP_MAX(10), .START_STEP(1)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .sw_ctrl    (sw_ctrl),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_step   (cfg_step),
        .cfg_level  (cfg_level),
        .led        (led),
        .frame_pulse(frame_pulse)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    // Starts one clock past a frame_pulse sample (negedge + 1) and spends exactly 20 clocks.
    // l0..l3 are the levels in effect for this frame; led is high 2 clocks per level unit.
    task automatic run_frame(input int f, input int l0, input int l1, input int l2, input int l3,
                             input bit sw, input bit we, input int ch, input int mode,
                             input int stp, input int lev, input bit stray);
        sw_ctrl = sw;
        exp_q.push_back(sw ? 2 * l0 : 0);
        exp_q.push_back(sw ? 2 * l1 : 0);
        exp_q.push_back(sw ? 2 * l2 : 0);
        exp_q.push_back(sw ? 2 * l3 : 0);
        tag_q.push_back(f);
        if (stray) begin
            repeat (5) @(posedge sys_clk);
            #1;
            cfg_we = 1'b1; cfg_ch = 4'd7; cfg_mode = 2'd1; cfg_step = 10'd5; cfg_level = 10'd2;
            @(posedge sys_clk);
            #1;
            cfg_we = 1'b0;
            repeat (13) @(posedge sys_clk);
        end else begin
            repeat (19) @(posedge sys_clk);
        end
        #1;
        if (we) begin
            cfg_we = 1'b1; cfg_ch = 4'(ch); cfg_mode = 2'(mode);
            cfg_step = 10'(stp); cfg_level = 10'(lev);
        end
        @(posedge sys_clk);
        #1;
        cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_step = '0; cfg_level = '0;
        @(negedge sys_clk);
        #1;
    endtask

    // Monitor: integrate led per channel over each frame window, compare on frame_pulse.
    initial begin
        int acc [NCH];
        int since;
        int tag;
        since = 0;
        for (int i = 0; i < NCH; i++) acc[i] = 0;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                since = 0;
                for (int i = 0; i < NCH; i++) acc[i] = 0;
            end else begin
                since++;
                for (int i = 0; i < NCH; i++) acc[i] += int'(led[i]);
                if (frame_pulse) begin
                    check("frame_period", since, 20);
                    check("frame_expected", (tag_q.size() > 0) ? 1 : 0, 1);
                    if (tag_q.size() > 0) begin
                        tag = tag_q.pop_front();
                        for (int i = 0; i < NCH; i++)
                            check($sformatf("frame%0d_ch%0d_high_cycles", tag, i), acc[i], exp_q.pop_front());
                    end
                    since = 0;
                    for (int i = 0; i < NCH; i++) acc[i] = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        sys_rst_n = 1'b0;
        sw_ctrl   = 1'b1;
        cfg_we    = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_step = '0; cfg_level = '0;
        repeat (3) @(negedge sys_clk);
        check("reset_led", int'(led), 0);
        check("reset_frame_pulse", int'(frame_pulse), 0);
        #1;
        sys_rst_n = 1'b1;

        //        f   ch0 ch1 ch2 ch3 sw we ch mode step lvl stray
        run_frame(0,  0,  0,  0,  0,  1, 0, 0, 0, 0,  0,  0);
        run_frame(1,  0,  0,  0,  0,  1, 0, 0, 0, 0,  0,  0);
        run_frame(2,  0,  0,  0,  0,  1, 0, 0, 0, 0,  0,  0);
        run_frame(3,  0,  0,  0,  0,  1, 0, 0, 0, 0,  0,  0);
        run_frame(4,  0,  0,  0,  0,  1, 1, 0, 1, 0,  3,  0);
        run_frame(5,  3,  0,  0,  0,  1, 1, 1, 2, 3,  0,  0);
        run_frame(6,  3,  0,  0,  0,  1, 1, 2, 3, 4,  0,  0);
        run_frame(7,  3,  3,  0,  0,  1, 1, 3, 2, 0,  5,  0);
        run_frame(8,  3,  6,  4,  5,  1, 0, 0, 0, 0,  0,  0);
        run_frame(9,  3,  9,  8,  6,  1, 0, 0, 0, 0,  0,  0);
        run_frame(10, 3, 10,  0,  7,  1, 0, 0, 0, 0,  0,  0);
        run_frame(11, 3,  7,  4,  8,  1, 0, 0, 0, 0,  0,  0);
        run_frame(12, 3,  4,  8,  9,  1, 0, 0, 0, 0,  0,  0);
        run_frame(13, 3,  1,  0, 10,  1, 0, 0, 0, 0,  0,  0);
        run_frame(14, 3,  0,  4,  9,  1, 0, 0, 0, 0,  0,  0);
        run_frame(15, 3,  3,  8,  8,  1, 1, 0, 1, 1,  0,  0);
        run_frame(16, 0,  6,  0,  7,  1, 1, 0, 1, 1, 15,  0);
        run_frame(17, 10, 9,  4,  6,  1, 1, 1, 2, 25, 0,  1);
        run_frame(18, 10, 0,  8,  5,  1, 1, 3, 3, 2,  1,  0);
        run_frame(19, 10, 10, 0,  1,  1, 0, 0, 0, 0,  0,  0);
        run_frame(20, 10, 0,  4,  3,  0, 0, 0, 0, 0,  0,  0);
        run_frame(21, 10, 10, 8,  5,  1, 1, 2, 0, 3,  7,  0);
        run_frame(22, 10, 0,  0,  7,  1, 0, 0, 0, 0,  0,  0);

        // Frame 23 levels are ch0=10, ch1=10, ch2 off, ch3=9: reset lands mid-frame.
        sw_ctrl = 1'b1;
        repeat (7) @(posedge sys_clk);
        #1;
        check("pre_reset_led", int'(led), 4'b1011);
        sys_rst_n = 1'b0;
        #1;
        check("mid_reset_led", int'(led), 0);
        check("mid_reset_frame_pulse", int'(frame_pulse), 0);
        repeat (3) @(negedge sys_clk);
        check("held_reset_led", int'(led), 0);
        #1;
        sys_rst_n = 1'b1;

        run_frame(100, 0, 0, 0, 0, 1, 1, 0, 1, 1, 5, 0);
        run_frame(101, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        run_frame(102, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge sys_clk);
        check("scoreboard_drained", tag_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
